// File: rtl/pp_pkg.sv
`default_nettype none
// ============================================================================
// pp_pkg : shared constants and FSM encoding for the preprocess row scheduler
// Rev 1.0
// ============================================================================
package pp_pkg;

  localparam int c_data_w     = 12;
  localparam int c_fill_w     = 11;
  localparam int c_h_active   = 640;
  localparam int c_v_active   = 480;
  localparam int c_gap_cycles = 2;
  localparam int c_col_w      = 10;
  localparam int c_row_w      = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2,
    S_GAP   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pp_rowcol_counter.sv
`default_nettype none
// ============================================================================
// pp_rowcol_counter : column/row position over a frame, wraps at frame end
// Rev 1.0
// ============================================================================
module pp_rowcol_counter
  import pp_pkg::*;
#(
  parameter int H_ACTIVE = c_h_active,
  parameter int V_ACTIVE = c_v_active
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_clear,
  input  logic               i_adv,
  output logic [c_col_w-1:0] o_col,
  output logic [c_row_w-1:0] o_row,
  output logic               o_last_col,
  output logic               o_last_row
);

  logic [c_col_w-1:0] r_col;
  logic [c_row_w-1:0] r_row;

  assign o_col      = r_col;
  assign o_row      = r_row;
  assign o_last_col = (r_col == c_col_w'(H_ACTIVE - 1));
  assign o_last_row = (r_row == c_row_w'(V_ACTIVE - 1));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_adv) begin
      if (o_last_col) begin
        r_col <= '0;
        r_row <= o_last_row ? '0 : r_row + c_row_w'(1);
      end else begin
        r_col <= r_col + c_col_w'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pp_row_scheduler.sv
`default_nettype none
// ============================================================================
// pp_row_scheduler : drains whole rows from the preprocess FIFO into the
// Gaussian stage with SOF/SOL/EOL/EOF tags.   Rev 1.0
// ============================================================================
module pp_row_scheduler
  import pp_pkg::*;
#(
  parameter int DATA_W     = c_data_w,
  parameter int FILL_W     = c_fill_w,
  parameter int H_ACTIVE   = c_h_active,
  parameter int V_ACTIVE   = c_v_active,
  parameter int GAP_CYCLES = c_gap_cycles
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_flush,
  input  logic               i_enable,
  output logic               o_rd,
  input  logic [DATA_W-1:0]  i_data,
  input  logic [FILL_W-1:0]  i_fill,
  input  logic               i_ready,
  output logic [DATA_W-1:0]  o_data,
  output logic               o_valid,
  output logic               o_sof,
  output logic               o_sol,
  output logic               o_eol,
  output logic               o_eof,
  output logic [c_row_w-1:0] o_row,
  output logic               o_busy
);

  localparam int c_gap_w = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t             r_state;
  state_t             w_next_state;
  logic [c_gap_w-1:0] r_gap_cnt;
  logic               r_rd;
  logic               r_valid;
  logic               r_sof;
  logic               r_sol;
  logic               r_eol;
  logic               r_eof;
  logic [c_col_w-1:0] w_col;
  logic [c_row_w-1:0] w_row;
  logic               w_last_col;
  logic               w_last_row;
  logic               w_row_ok;
  logic               w_gap_done;

  assign w_row_ok   = (i_fill >= FILL_W'(H_ACTIVE)) && i_ready;
  assign w_gap_done = (r_gap_cnt == c_gap_w'(GAP_CYCLES - 1));

  pp_rowcol_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_rowcol (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_clear    (i_flush),
    .i_adv      (r_rd),
    .o_col      (w_col),
    .o_row      (w_row),
    .o_last_col (w_last_col),
    .o_last_row (w_last_row)
  );

  // The last GAP cycle also evaluates the start condition so back-to-back
  // rows are separated by exactly GAP_CYCLES idle read cycles.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_enable) w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (!i_enable)    w_next_state = S_IDLE;
        else if (w_row_ok) w_next_state = S_BURST;
      end
      S_BURST: begin
        if (w_last_col) w_next_state = w_last_row ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (w_gap_done) begin
          if (!i_enable)     w_next_state = S_IDLE;
          else if (w_row_ok) w_next_state = S_BURST;
          else               w_next_state = S_WAIT;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
    if (i_flush) w_next_state = S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state   <= S_IDLE;
      r_rd      <= 1'b0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_next_state;
      r_rd      <= (w_next_state == S_BURST);
      r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + c_gap_w'(1) : '0;
    end
  end

  // One-stage tag pipeline aligned with FIFO read latency.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_valid <= 1'b0;
      r_sol   <= 1'b0;
      r_eol   <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_sol   <= 1'b0;
      r_eol   <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
    end else begin
      r_valid <= r_rd;
      r_sol   <= r_rd && (w_col == '0);
      r_eol   <= r_rd && w_last_col;
      r_sof   <= r_rd && (w_col == '0) && (w_row == '0);
      r_eof   <= r_rd && w_last_col && w_last_row;
    end
  end

  assign o_rd    = r_rd;
  assign o_valid = r_valid;
  assign o_sol   = r_sol;
  assign o_eol   = r_eol;
  assign o_sof   = r_sof;
  assign o_eof   = r_eof;
  assign o_data  = r_valid ? i_data : '0;
  assign o_row   = w_row;
  assign o_busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire
